// File: rtl/matmul_operand_loader_pkg.sv
// Shared operand geometry for the loader and the matrix-multiply unit.
// Both sides import these constants so packing widths always agree.
// Also holds the load FSM state encoding.
package matmul_operand_loader_pkg;

  localparam int MM_DATA_WIDTH = 8;
  localparam int MM_ROW_LEN1   = 3;
  localparam int MM_COL_LEN1   = 3;
  localparam int MM_ROW_LEN2   = 3;
  localparam int MM_COL_LEN2   = 3;
  localparam int MM_MAT1_SIZE  = MM_ROW_LEN1 * MM_COL_LEN1 * MM_DATA_WIDTH;
  localparam int MM_MAT2_SIZE  = MM_ROW_LEN2 * MM_COL_LEN2 * MM_DATA_WIDTH;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } load_state_e;

endpackage

// File: rtl/matmul_operand_loader_operand_shift_reg.sv
// Shift-in shadow register: each enabled edge pushes one element into the LSBs.
// Latency: one edge per element; the first element ends up in the MSBs.
// No backpressure; the caller gates shift_en.
module operand_shift_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 9
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        shift_en,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic [DATA_WIDTH*DEPTH-1:0] dout
);

  localparam int W = DATA_WIDTH * DEPTH;

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next value: shift left by one element and insert din at the bottom.
  always_comb begin
    data_d = data_q;
    if (shift_en) begin
      data_d = W'({data_q, din});
    end
  end

  // Storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign dout = data_q;

endmodule

// File: rtl/matmul_operand_loader.sv
// Collects streamed elements into double-buffered operand registers for the multiplier.
// Latency: commit one edge after the last accepted element (if no hold), start pulses for one cycle.
// in_ready drops once a full shadow set is waiting on the hold window.
module matmul_operand_loader
  import matmul_operand_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = MM_DATA_WIDTH,
  parameter int ROW_LEN1    = MM_ROW_LEN1,
  parameter int COL_LEN1    = MM_COL_LEN1,
  parameter int ROW_LEN2    = MM_ROW_LEN2,
  parameter int COL_LEN2    = MM_COL_LEN2,
  parameter int HOLD_CYCLES = 4,
  parameter int MAT1_SIZE   = ROW_LEN1 * COL_LEN1 * DATA_WIDTH,
  parameter int MAT2_SIZE   = ROW_LEN2 * COL_LEN2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [MAT1_SIZE-1:0]  Mat1_out,
  output logic [MAT2_SIZE-1:0]  Mat2_out,
  output logic                  start,
  output logic                  busy
);

  localparam int N1 = ROW_LEN1 * COL_LEN1;
  localparam int N2 = ROW_LEN2 * COL_LEN2;
  localparam int NT = N1 + N2;
  localparam int CW = $clog2(NT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  load_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [MAT1_SIZE-1:0] mat1_q, mat1_d;
  logic [MAT2_SIZE-1:0] mat2_q, mat2_d;
  logic           start_q, start_d;
  logic           busy_q, busy_d;

  logic full, accept, commit, shift_a, shift_b;
  logic [MAT1_SIZE-1:0] shadow1;
  logic [MAT2_SIZE-1:0] shadow2;

  assign full     = (state_q == FULL);
  assign in_ready = !full && !reset;
  assign accept   = in_valid && in_ready;
  assign commit   = full && (hold_q == '0) && !clear;
  // A clear on the same edge drops the element, so it must not reach the shadows.
  assign shift_a  = accept && !clear && (state_q == LOAD_A);
  assign shift_b  = accept && !clear && (state_q == LOAD_B);

  operand_shift_reg #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(N1)) u_shadow1 (
    .clk      (clk),
    .clr      (reset),
    .shift_en (shift_a),
    .din      (in_data),
    .dout     (shadow1)
  );

  operand_shift_reg #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(N2)) u_shadow2 (
    .clk      (clk),
    .clr      (reset),
    .shift_en (shift_b),
    .din      (in_data),
    .dout     (shadow2)
  );

  // Next-state: clear beats commit beats element acceptance; hold counts down independently.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    mat1_d  = mat1_q;
    mat2_d  = mat2_q;
    start_d = 1'b0;
    if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
    if (clear) begin
      state_d = LOAD_A;
      cnt_d   = '0;
    end else if (commit) begin
      mat1_d  = shadow1;
      mat2_d  = shadow2;
      start_d = 1'b1;
      hold_d  = HW'(HOLD_CYCLES);
      cnt_d   = '0;
      state_d = LOAD_A;
    end else if (accept) begin
      cnt_d = cnt_q + CW'(1);
      if (state_q == LOAD_A && cnt_q == CW'(N1 - 1)) begin
        state_d = LOAD_B;
      end
      if (state_q == LOAD_B && cnt_q == CW'(NT - 1)) begin
        state_d = FULL;
      end
    end
    busy_d = (hold_d != '0);
  end

  // Register all state and outputs; reset aborts any load or hold in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      hold_q  <= '0;
      mat1_q  <= '0;
      mat2_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      mat1_q  <= mat1_d;
      mat2_q  <= mat2_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign Mat1_out = mat1_q;
  assign Mat2_out = mat2_q;
  assign start    = start_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Directed bench for the operand loader: two instances, default hold and a long hold of 30.
// Inputs driven #1 after the rising edge, outputs sampled there too; handshakes sampled at negedge.
// Start pulses tracked by negedge monitors.
module tb_matmul_operand_loader;

  logic clk = 1'b0;
  logic reset, clear;
  logic v1, r1, st1, bz1;
  logic v2, r2, st2, bz2;
  logic [7:0]  d1, d2;
  logic [71:0] m1a, m2a, m1b, m2b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int st1_n = 0, st1_cyc = 0, st1_prev = 0;
  int st2_n = 0, st2_cyc = 0, st2_prev = 0;

  logic [7:0] ea[18];

  localparam logic [71:0] M1_SEQ  = 72'h010203040506070809;
  localparam logic [71:0] M2_REV  = 72'h090807060504030201;
  localparam logic [71:0] M2_SEQ  = 72'h0A0B0C0D0E0F101112;
  localparam logic [71:0] M1_F30  = 72'h303132333435363738;
  localparam logic [71:0] M2_F30  = 72'h393A3B3C3D3E3F4041;
  localparam logic [71:0] ONES    = {72{1'b1}};

  always #5 clk = ~clk;

  matmul_operand_loader dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(v1), .in_ready(r1),
    .in_data(d1), .Mat1_out(m1a), .Mat2_out(m2a), .start(st1), .busy(bz1)
  );

  matmul_operand_loader #(.HOLD_CYCLES(30)) dut_h (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(v2), .in_ready(r2),
    .in_data(d2), .Mat1_out(m1b), .Mat2_out(m2b), .start(st2), .busy(bz2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record count and cycle of each start pulse per instance.
  always @(negedge clk) begin
    if (st1) begin
      st1_n    <= st1_n + 1;
      st1_prev <= st1_cyc;
      st1_cyc  <= cyc;
    end
    if (st2) begin
      st2_n    <= st2_n + 1;
      st2_prev <= st2_cyc;
      st2_cyc  <= cyc;
    end
  end

  task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      v1 = v; d1 = d;
    end else begin
      v2 = v; d2 = d;
    end
  endtask

  // Sends e[0..n-1]; optional idle cycle between elements; clear raised with element clr_at.
  task automatic send_set(input int sel, input logic [7:0] e[18], input int n,
                          input bit gaps, input int clr_at, output int last);
    int i;
    int budget;
    bit tog;
    bit acc;
    i = 0; budget = 0; tog = 1'b0; last = -1;
    while (i < n && budget < 300) begin
      if (gaps && tog) begin
        drive(sel, 1'b0, 8'h00);
        clear = 1'b0;
      end else begin
        drive(sel, 1'b1, e[i]);
        clear = (i == clr_at);
      end
      tog = !tog;
      @(negedge clk);
      acc = (sel == 0) ? (v1 && r1) : (v2 && r2);
      @(posedge clk);
      #1;
      budget++;
      if (acc) begin
        last = cyc;
        i++;
      end
    end
    clear = 1'b0;
    chk_vec("accepts", i, n);
  endtask

  task automatic wait_idle1();
    int budget;
    budget = 0;
    while (bz1 && budget < 100) begin
      step(1);
      budget++;
    end
    chk_vec("idle_wait", bz1, 1'b0);
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < 18; i++) begin
      case (kind)
        0: ea[i] = (i < 9) ? 8'(i + 1) : 8'(18 - i);
        1: ea[i] = 8'hFF;
        2: ea[i] = 8'(i + 1);
        3: ea[i] = 8'(8'hA0 + i);
        default: ea[i] = 8'(8'h30 + i);
      endcase
    end
  endtask

  initial begin
    int last, last1, last2, base, k;
    reset = 1'b1; clear = 1'b0;
    v1 = 1'b0; d1 = 8'h00; v2 = 1'b0; d2 = 8'h00;
    step(2);
    chk_vec("rst_ready_low", r1, 1'b0);
    reset = 1'b0;
    #1;
    chk_vec("rst_ready", r1, 1'b1);
    chk_vec("rst_m1", m1a, 72'h0);
    chk_vec("rst_m2", m2a, 72'h0);
    chk_vec("rst_start", st1, 1'b0);
    chk_vec("rst_busy", bz1, 1'b0);

    // Test 1: continuous stream
    fill(0);
    base = st1_n;
    send_set(0, ea, 18, 1'b0, -1, last);
    v1 = 1'b0;
    chk_vec("t1_start_e0", st1, 1'b0);
    step(1);
    chk_vec("t1_start", st1, 1'b1);
    chk_vec("t1_lat", cyc - last, 1);
    chk_vec("t1_m1", m1a, M1_SEQ);
    chk_vec("t1_m2", m2a, M2_REV);
    chk_vec("t1_busy0", bz1, 1'b1);
    for (k = 1; k <= 3; k++) begin
      step(1);
      chk_vec("t1_busy", bz1, 1'b1);
      chk_vec("t1_start_low", st1, 1'b0);
    end
    step(1);
    chk_vec("t1_busy_end", bz1, 1'b0);
    chk_vec("t1_pulses", st1_n - base, 1);

    // Test 2: valid on alternate cycles
    base = st1_n;
    send_set(0, ea, 18, 1'b1, -1, last);
    v1 = 1'b0;
    chk_vec("t2_start_e0", st1, 1'b0);
    step(1);
    chk_vec("t2_start", st1, 1'b1);
    chk_vec("t2_m1", m1a, M1_SEQ);
    chk_vec("t2_m2", m2a, M2_REV);
    step(5);
    chk_vec("t2_pulses", st1_n - base, 1);
    chk_vec("t2_cyc", st1_cyc - last, 1);

    // Test 3: back-to-back sets
    wait_idle1();
    base = st1_n;
    send_set(0, ea, 18, 1'b0, -1, last1);
    fill(1);
    send_set(0, ea, 18, 1'b0, -1, last2);
    v1 = 1'b0;
    chk_vec("t3_hold_m1", m1a, M1_SEQ);
    chk_vec("t3_hold_m2", m2a, M2_REV);
    step(1);
    chk_vec("t3_start2", st1, 1'b1);
    chk_vec("t3_m1", m1a, ONES);
    chk_vec("t3_m2", m2a, ONES);
    step(1);
    chk_vec("t3_pulses", st1_n - base, 2);
    chk_vec("t3_period", st1_cyc - st1_prev, 19);

    // Test 4: long hold on the second instance
    fill(0);
    send_set(1, ea, 18, 1'b0, -1, last1);
    fill(1);
    send_set(1, ea, 18, 1'b0, -1, last2);
    v2 = 1'b0;
    chk_vec("t4_set2_span", last2 - last1, 19);
    chk_vec("t4_m1_held", m1b, M1_SEQ);
    while (cyc < last1 + 31) begin
      step(1);
      chk_vec("t4_ready_low", r2, 1'b0);
    end
    step(1);
    chk_vec("t4_start2", st2, 1'b1);
    chk_vec("t4_ready_back", r2, 1'b1);
    chk_vec("t4_m1", m1b, ONES);
    step(1);
    chk_vec("t4_first_cyc", st2_prev - last1, 1);
    chk_vec("t4_spacing", st2_cyc - st2_prev, 31);

    // Test 5: reset mid-load
    wait_idle1();
    fill(2);
    send_set(0, ea, 5, 1'b0, -1, last);
    v1 = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_vec("t5_rst_m1", m1a, 72'h0);
    base = st1_n;
    send_set(0, ea, 18, 1'b0, -1, last);
    v1 = 1'b0;
    step(1);
    chk_vec("t5_start", st1, 1'b1);
    chk_vec("t5_m1", m1a, M1_SEQ);
    chk_vec("t5_m2", m2a, M2_SEQ);
    step(1);
    chk_vec("t5_pulses", st1_n - base, 1);

    // Test 6: clear with the third B element
    wait_idle1();
    base = st1_n;
    fill(3);
    send_set(0, ea, 12, 1'b0, 11, last);
    v1 = 1'b0;
    step(3);
    chk_vec("t6_no_start", st1_n - base, 0);
    chk_vec("t6_m1_kept", m1a, M1_SEQ);
    fill(4);
    send_set(0, ea, 18, 1'b0, -1, last);
    v1 = 1'b0;
    chk_vec("t6_pre_m2", m2a, M2_SEQ);
    chk_vec("t6_pre_start", st1, 1'b0);
    step(1);
    chk_vec("t6_start", st1, 1'b1);
    chk_vec("t6_m1", m1a, M1_F30);
    chk_vec("t6_m2", m2a, M2_F30);
    step(1);
    chk_vec("t6_pulses", st1_n - base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
